// File: rtl/byte_stream_fifo_pkg.sv
// Shared constants for the byte stream path, so the capture stage and the
// buffering FIFO agree on byte width and default depth.
package byte_stream_fifo_pkg;

    localparam int unsigned DATA_W_DEFAULT = 8;
    localparam int unsigned DEPTH_DEFAULT  = 4;
    localparam int unsigned ADDR_W_DEFAULT = $clog2(DEPTH_DEFAULT);

    // Occupancy must represent 0..depth inclusive, so it needs one bit more
    // than the pointer.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/byte_stream_fifo_if.sv
// Stream and control bundle for the byte stream FIFO. The master side is the
// producer/consumer/debug environment; the slave side is the FIFO itself.
interface byte_stream_fifo_if
    import byte_stream_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
);

    // Upstream byte stream
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    // Downstream byte stream (first-word-fall-through head)
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    // Control and debug visibility
    logic              flush;
    logic              clr_overflow;
    logic [ADDR_W:0]   count;
    logic              overflow;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready,
        output flush,
        output clr_overflow,
        input  count,
        input  overflow
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready,
        input  flush,
        input  clr_overflow,
        output count,
        output overflow
    );

endinterface

// File: rtl/byte_stream_fifo.sv
// First-word-fall-through byte FIFO with occupancy count, synchronous flush
// and a sticky overflow flag. Handshake outputs are decoded purely from the
// registered count, so there is no combinational path from in_valid or
// out_ready to in_ready or out_valid.
module byte_stream_fifo
    import byte_stream_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned DEPTH  = DEPTH_DEFAULT,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    byte_stream_fifo_if.slave bus
);

    localparam int unsigned       CountW    = count_width(DEPTH);
    localparam logic [CountW-1:0] FullCount = CountW'(DEPTH);
    localparam logic [CountW-1:0] CountOne  = CountW'(1);
    localparam logic [ADDR_W-1:0] PtrOne    = ADDR_W'(1);

    // Register array rather than a RAM macro: every entry is cleared on reset.
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CountW-1:0] count_q, count_d;
    logic              overflow_q, overflow_d;

    logic              in_ready;
    logic              out_valid;
    logic              push;
    logic              pop;

    // Handshake decode from registered occupancy; flush suppresses both moves.
    always_comb begin
        in_ready  = (count_q != FullCount);
        out_valid = (count_q != '0);
        push      = bus.in_valid && in_ready && !bus.flush;
        pop       = out_valid && bus.out_ready && !bus.flush;
    end

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrOne;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CountOne;
                2'b01:   count_d = count_q - CountOne;
                default: count_d = count_q;
            endcase
        end

        // Set is evaluated after clear so a same-cycle offer-while-full wins.
        if (bus.clr_overflow) begin
            overflow_d = 1'b0;
        end
        if (bus.in_valid && !in_ready) begin
            overflow_d = 1'b1;
        end
    end

    // Pointer, occupancy and flag state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage write; flush leaves contents in place, only pointers move.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = mem_q[rd_ptr_q];
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_byte_stream_fifo.sv
// Directed bench for byte_stream_fifo. Stimulus pushes the bytes it expects
// to see into a scoreboard queue; a negedge monitor pops and compares every
// accepted head. Flag/count checks are made directly against hand values.
module tb_byte_stream_fifo;

    logic clk;
    logic reset;

    int tests;
    int fails;

    logic [7:0] exp_q[$];

    byte_stream_fifo_if #(.DATA_W(8), .ADDR_W(2)) bus ();

    byte_stream_fifo #(
        .DATA_W(8),
        .DEPTH (4),
        .ADDR_W(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid     = 1'b0;
        bus.in_data      = 8'h00;
        bus.out_ready    = 1'b0;
        bus.flush        = 1'b0;
        bus.clr_overflow = 1'b0;
    endtask

    // Single-cycle accepted push; expectation recorded for the monitor.
    task automatic push_byte(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        exp_q.push_back(b);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        bus.out_ready = 1'b1;
        repeat (n) tick();
        bus.out_ready = 1'b0;
    endtask

    // Scoreboard monitor: a head accepted at the coming edge is checked here.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL pop_unexpected: got 0x%0h expected no data at %0t",
                         bus.out_data, $time);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (bus.out_data !== e) begin
                    fails++;
                    $display("FAIL pop_data: got 0x%0h expected 0x%0h at %0t",
                             bus.out_data, e, $time);
                end
            end
        end
    end

    // Occupancy must stay within 0..DEPTH.
    always @(negedge clk) begin
        if (!reset) begin
            assert (bus.count <= 3'd4)
            else begin
                fails++;
                $display("FAIL count_range: got %0d expected <= 4 at %0t", bus.count, $time);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'h00);
        check("rst_overflow", 32'(bus.overflow), 32'd0);

        // Single byte, one-cycle latency, then pop
        push_byte(8'h11);
        check("single_valid", 32'(bus.out_valid), 32'd1);
        check("single_data", 32'(bus.out_data), 32'h11);
        check("single_count", 32'(bus.count), 32'd1);
        drain(1);
        check("single_drained_count", 32'(bus.count), 32'd0);
        check("single_drained_valid", 32'(bus.out_valid), 32'd0);

        // Fill, overflow while full, drain in order, clear flag
        push_byte(8'hA1);
        push_byte(8'hA2);
        push_byte(8'hA3);
        push_byte(8'hA4);
        check("full_count", 32'(bus.count), 32'd4);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        tick();
        bus.in_valid = 1'b0;
        check("ovf_set", 32'(bus.overflow), 32'd1);
        check("ovf_count", 32'(bus.count), 32'd4);
        drain(4);
        check("ovf_drained_count", 32'(bus.count), 32'd0);
        check("ovf_still_set", 32'(bus.overflow), 32'd1);
        bus.clr_overflow = 1'b1;
        tick();
        bus.clr_overflow = 1'b0;
        check("ovf_cleared", 32'(bus.overflow), 32'd0);

        // Streaming through the wrap: count holds at 1
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(i);
            exp_q.push_back(8'(i));
            tick();
            check("stream_count", 32'(bus.count), 32'd1);
        end
        bus.in_valid = 1'b0;
        tick();
        bus.out_ready = 1'b0;
        check("stream_end_count", 32'(bus.count), 32'd0);

        // Full with pop and offer together: only the pop happens; set beats clear
        push_byte(8'hB1);
        push_byte(8'hB2);
        push_byte(8'hB3);
        push_byte(8'hB4);
        bus.in_valid     = 1'b1;
        bus.in_data      = 8'hB0;
        bus.out_ready    = 1'b1;
        bus.clr_overflow = 1'b1;
        tick();
        bus.in_valid     = 1'b0;
        bus.out_ready    = 1'b0;
        bus.clr_overflow = 1'b0;
        check("fullpop_count", 32'(bus.count), 32'd3);
        check("fullpop_overflow", 32'(bus.overflow), 32'd1);
        check("fullpop_head", 32'(bus.out_data), 32'hB2);
        drain(3);
        check("fullpop_drained", 32'(bus.count), 32'd0);
        bus.clr_overflow = 1'b1;
        tick();
        bus.clr_overflow = 1'b0;

        // Flush with simultaneous push: push dropped, overflow untouched
        push_byte(8'hD1);
        push_byte(8'hD2);
        push_byte(8'hD3);
        check("preflush_count", 32'(bus.count), 32'd3);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hC0;
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        check("flush_count", 32'(bus.count), 32'd0);
        check("flush_valid", 32'(bus.out_valid), 32'd0);
        check("flush_overflow", 32'(bus.overflow), 32'd0);
        push_byte(8'hC1);
        check("postflush_head", 32'(bus.out_data), 32'hC1);
        check("postflush_count", 32'(bus.count), 32'd1);
        drain(1);

        // Asynchronous reset mid-stream
        push_byte(8'hE1);
        push_byte(8'hE2);
        check("prereset_count", 32'(bus.count), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", 32'(bus.out_valid), 32'd0);
        check("async_rst_count", 32'(bus.count), 32'd0);
        exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("post_rst_out_data", 32'(bus.out_data), 32'h00);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/byte_stream_fifo.md
Name: byte_stream_fifo

Overview:
- Downstream buffering stage for the 8-bit registered byte stream produced by the capture pipeline.
- Decouples the always-advancing producer from a consumer that can stall, using a valid/ready handshake.
- First-word-fall-through FIFO with occupancy count, flush, and a sticky overflow flag for debug visibility.

Parameters:
- DATA_W, 8, byte width of stored entries.
- DEPTH, 4, number of entries; must be a power of two and at least 2.
- ADDR_W, 2, log2(DEPTH); pointer width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  DATA_W  byte from the upstream register stage.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  FIFO can accept a byte this cycle.
- out_data  output  DATA_W  head entry (FWFT).
- out_valid  output  1  head entry is valid.
- out_ready  input  1  consumer accepts the head this cycle.
- flush  input  1  synchronous clear of contents.
- clr_overflow  input  1  synchronous clear of the sticky overflow flag.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a byte was offered while full.

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr, rd_ptr, count and overflow = 0.
  - All storage entries = 0.
  - out_valid=0, out_data=0, in_ready=1.
- in_ready = (count != DEPTH). out_valid = (count != 0). Both are decoded from registered count; there is no combinational path from in_valid or out_ready.
- push = in_valid && in_ready: writes mem[wr_ptr], then wr_ptr+1 mod DEPTH.
- pop = out_valid && out_ready: rd_ptr+1 mod DEPTH.
- out_data = mem[rd_ptr], read combinationally. Latency: a byte pushed at edge N is visible with out_valid=1 after edge N, i.e. 1 cycle. No empty-bypass.
- count update: push only +1; pop only -1; both or neither unchanged.
- Full with pop and in_valid both high: in_ready=0, so only the pop occurs and count becomes DEPTH-1. There is no same-cycle refill.
- Empty: out_valid=0, so out_ready is ignored and count never underflows.
- Pointers wrap naturally at DEPTH. Ordering is strictly FIFO across the wrap.
- overflow is set on any cycle with in_valid=1 and in_ready=0. It holds until clr_overflow=1 or reset. If set and clear occur in the same cycle, set wins.
- flush=1: next edge sets wr_ptr, rd_ptr and count to 0. flush has priority over push and pop in that cycle; a simultaneous push is dropped without setting overflow. Storage is not cleared and overflow is unaffected.
- Reset asserted mid-transfer immediately discards all contents. out_valid drops asynchronously.
- count is never observed outside 0..DEPTH; a bench assertion checks this.

Decomposition:
- Shared package holds DATA_W_DEFAULT=8, the FIFO DEPTH default, and the count width derivation, so the capture stage and this stage agree on byte width.
- No sub-module: the storage array, pointers and count are small enough to live in one module.
- Storage is a register array, not a RAM macro, because it requires async reset.

Test Plan:
- Reset, then idle → out_valid=0, in_ready=1, count=0, out_data=0x00, overflow=0.
- Push 0x11 at one edge, out_ready=0 → next cycle out_valid=1, out_data=0x11, count=1; then out_ready=1 for one cycle → count=0, out_valid=0.
- Push 0xA1,0xA2,0xA3,0xA4 with out_ready=0 → count=4, in_ready=0. Offer 0xA5 → overflow=1, 0xA5 dropped. Drain → 0xA1..0xA4 in order. Pulse clr_overflow → overflow=0.
- Continuous in_valid=1 and out_ready=1 with bytes 0x00..0x0B → output sequence 0x00..0x0B unbroken, count stays at 1, pointers wrap 3 times.
- Full FIFO with in_valid=1 offering 0xB0 and out_ready=1 in the same cycle → head pops, 0xB0 not accepted, overflow=1, count=3.
- 3 entries held, flush=1 with in_valid=1 offering 0xC0 → next cycle count=0, out_valid=0, overflow unchanged. A later push of 0xC1 appears as the head.
- Assert reset mid-stream with count=2 → out_valid=0 and count=0 immediately, before the next clock edge.
